// File: rtl/pipeline_unit.sv
// pipeline_unit: two-stage pipelined dot product C = A1*B1 + A2*B2 on 32-bit unsigned operands.
// Define PIPELINE_SAT_EN to clamp products and sum to 0xFFFFFFFF instead of wrapping.
module pipeline_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [31:0] B1,
  input  logic [31:0] B2,
  output logic [31:0] C
);
  logic [31:0] r_p1, r_p2;
  logic [31:0] w_p1, w_p2, w_c;
`ifdef PIPELINE_SAT_EN
  logic [63:0] w_m1, w_m2;
  logic [32:0] w_sum;
  always_comb begin
    w_m1  = {32'd0, A1} * {32'd0, B1};
    w_m2  = {32'd0, A2} * {32'd0, B2};
    w_p1  = |w_m1[63:32] ? '1 : w_m1[31:0];
    w_p2  = |w_m2[63:32] ? '1 : w_m2[31:0];
    w_sum = {1'b0, r_p1} + {1'b0, r_p2};
    w_c   = w_sum[32] ? '1 : w_sum[31:0];
  end
`else
  // Only the low 32 bits of each product and of the sum survive, so narrow arithmetic suffices.
  always_comb begin
    w_p1 = A1 * B1;
    w_p2 = A2 * B2;
    w_c  = r_p1 + r_p2;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1 <= '0;
      r_p2 <= '0;
      C    <= '0;
    end else begin
      r_p1 <= w_p1;
      r_p2 <= w_p2;
      C    <= w_c;
    end
  end
endmodule

// File: tb/tb_pipeline_unit.sv
// tb_pipeline_unit: directed and random stimulus for pipeline_unit, checked against a
// cycle-level dot-product model plus hand-computed literal expectations.
module tb_pipeline_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A1 = '0, A2 = '0, B1 = '0, B2 = '0;
  logic [31:0] C;
  int checks = 0, errors = 0;
`ifdef PIPELINE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_unit dut (.clk(clk), .reset(reset), .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C(C));

  function automatic logic [31:0] dot(input logic [31:0] a1, b1, a2, b2);
    logic [63:0] p1, p2, s;
    p1 = 64'(a1) * 64'(b1);
    p2 = 64'(a2) * 64'(b2);
    if (SAT) begin
      if (p1 > 64'hFFFF_FFFF) p1 = 64'hFFFF_FFFF;
      if (p2 > 64'hFFFF_FFFF) p2 = 64'hFFFF_FFFF;
      s = p1 + p2;
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    end else begin
      s = (p1 % 64'h1_0000_0000) + (p2 % 64'h1_0000_0000);
      s = s % 64'h1_0000_0000;
    end
    return s[31:0];
  endfunction

  // Model: C after an edge is 0 if reset is seen at this edge or the previous one,
  // otherwise the dot product of the inputs sampled at the previous edge.
  bit          known = 1'b0, exp_ok = 1'b0, prev_rst = 1'b1;
  logic [31:0] pa1, pb1, pa2, pb2, exp_c;
  always @(posedge clk) begin
    if (reset) begin
      exp_c  = '0;
      exp_ok = 1'b1;
      known  = 1'b1;
    end else if (known) begin
      exp_c = prev_rst ? 32'd0 : dot(pa1, pb1, pa2, pb2);
    end
    prev_rst = reset;
    pa1 = A1; pb1 = B1; pa2 = A2; pb2 = B2;
  end

  always @(negedge clk) begin
    if (exp_ok) begin
      checks++;
      if (C !== exp_c) begin
        errors++;
        $display("FAIL model: C=%h expected %h at %0t", C, exp_c, $time);
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] a1, b1, a2, b2);
    @(negedge clk);
    reset = r; A1 = a1; B1 = b1; A2 = a2; B2 = b2;
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    checks++;
    if (C !== exp) begin
      errors++;
      $display("FAIL %s: C=%h expected %h", name, C, exp);
    end
  endtask

  initial begin
    drive(1, $urandom, $urandom, $urandom, $urandom);
    drive(1, $urandom, $urandom, $urandom, $urandom);
    drive(0, 0, 0, 0, 0);
    lit("reset_hold", 32'd0);
    drive(0, 0, 0, 0, 0);
    lit("idle_zero_a", 32'd0);
    drive(0, 0, 0, 0, 0);
    lit("idle_zero_b", 32'd0);
    drive(0, 0, 1, 2, 3);
    drive(0, 4, 2, 1, 0);
    drive(0, 0, 0, 0, 0);
    lit("basic1", 32'd6);
    drive(0, 0, 0, 0, 0);
    lit("basic2", 32'd8);
    drive(0, 32'h1_0000, 32'h1_0000, 0, 0);
    drive(0, 1, 1, 32'hFFFF_FFFF, 1);
    drive(0, 0, 0, 0, 0);
    lit("ovf_product", SAT ? 32'hFFFF_FFFF : 32'd0);
    drive(0, 0, 0, 0, 0);
    lit("ovf_sum", SAT ? 32'hFFFF_FFFF : 32'd0);
    drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    lit("max_operands", SAT ? 32'hFFFF_FFFF : 32'd2);
    drive(0, 3, 5, 7, 11);
    drive(0, 2, 2, 2, 2);
    drive(1, 9, 9, 9, 9);
    drive(0, 1, 2, 3, 4);
    lit("rst_flush", 32'd0);
    drive(0, 0, 0, 0, 0);
    lit("rst_bubble", 32'd0);
    drive(0, 0, 0, 0, 0);
    lit("rst_first", 32'd14);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)
        drive(0, $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 65535), $urandom_range(0, 65535));
      else
        drive(0, $urandom, $urandom, $urandom, $urandom);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
